// File: rtl/pcap_axi_wr_sink.sv
// AXI3 write-channel responder that stores PCAP DMA write bursts into a sample RAM for checkers.
// Latency: B response the cycle after the last W beat; rd_data_o one cycle after rd_addr_i.
// Backpressure: one outstanding burst; wready held low in IDLE/RESP and whenever stall_i is high; B held until bready.
//
// Ports:
//   clk_i, resetn_i          single clock, asynchronous active-low reset
//   s_axi_aw*/w*/b*          AXI3 slave write address, data and response channels
//   stall_i                  forces wready low to inject backpressure
//   rd_addr_i / rd_data_o    checker read-back port, registered (old data on same-address write)
//   beat_count_o             beats written to RAM
//   burst_count_o            B responses issued
//   err_count_o              SLVERR responses issued
module pcap_axi_wr_sink #(
    parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
    parameter int          AW        = 12,
    parameter int          ID_W      = 6
) (
    input  logic            clk_i,
    input  logic            resetn_i,
    input  logic [ID_W-1:0] s_axi_awid,
    input  logic [31:0]     s_axi_awaddr,
    input  logic [3:0]      s_axi_awlen,
    input  logic [2:0]      s_axi_awsize,
    input  logic [1:0]      s_axi_awburst,
    input  logic            s_axi_awvalid,
    output logic            s_axi_awready,
    input  logic [31:0]     s_axi_wdata,
    input  logic [3:0]      s_axi_wstrb,
    input  logic            s_axi_wlast,
    input  logic            s_axi_wvalid,
    output logic            s_axi_wready,
    output logic [ID_W-1:0] s_axi_bid,
    output logic [1:0]      s_axi_bresp,
    output logic            s_axi_bvalid,
    input  logic            s_axi_bready,
    input  logic            stall_i,
    input  logic [AW-1:0]   rd_addr_i,
    output logic [31:0]     rd_data_o,
    output logic [31:0]     beat_count_o,
    output logic [31:0]     burst_count_o,
    output logic [15:0]     err_count_o
);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_RESP} state_t;

    state_t          state, state_nxt;
    logic            rst_done;     // keeps awready low for the first cycle out of reset
    logic [ID_W-1:0] id_q;
    logic [AW-1:0]   ptr;
    logic [3:0]      beats_left;
    logic            err;
    logic [32:0]     off;          // bit 32 set when awaddr is below the window
    logic            aw_err;
    logic            aw_hs, w_hs, b_hs;
    logic [31:0]     ram [0:(1<<AW)-1];

    // Address checks. The burst must fit entirely inside the window: no wrap.
    always_comb begin
        off    = {1'b0, s_axi_awaddr} - {1'b0, BASE_ADDR};
        aw_err = (s_axi_awsize != 3'b010) || (s_axi_awburst != 2'b01) ||
                 (off[1:0] != 2'b00) || off[32] || (|off[31:AW+2]) ||
                 (({1'b0, off[AW+1:2]} + {{(AW-3){1'b0}}, s_axi_awlen}) >
                  {1'b0, {AW{1'b1}}});
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) state <= S_IDLE;
        else           state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        s_axi_awready = 1'b0;
        s_axi_wready  = 1'b0;
        s_axi_bvalid  = 1'b0;
        case (state)
            S_IDLE: begin
                s_axi_awready = rst_done;
                if (s_axi_awvalid && rst_done) state_nxt = S_DATA;
            end
            S_DATA: begin
                s_axi_wready = !stall_i;
                // Leave on the final counted beat or on an early wlast.
                if (s_axi_wvalid && !stall_i && (beats_left == 4'd0 || s_axi_wlast))
                    state_nxt = S_RESP;
            end
            S_RESP: begin
                s_axi_bvalid = 1'b1;
                if (s_axi_bready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign aw_hs       = s_axi_awvalid && s_axi_awready;
    assign w_hs        = s_axi_wvalid && s_axi_wready;
    assign b_hs        = s_axi_bvalid && s_axi_bready;
    assign s_axi_bid   = (state == S_RESP) ? id_q : '0;
    assign s_axi_bresp = (state == S_RESP && err) ? 2'b10 : 2'b00;

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            rst_done      <= 1'b0;
            id_q          <= '0;
            ptr           <= '0;
            beats_left    <= '0;
            err           <= 1'b0;
            beat_count_o  <= '0;
            burst_count_o <= '0;
            err_count_o   <= '0;
        end else begin
            rst_done <= 1'b1;
            if (aw_hs) begin
                id_q       <= s_axi_awid;
                ptr        <= off[AW+1:2];
                beats_left <= s_axi_awlen;
                err        <= aw_err;
            end
            if (w_hs) begin
                // Beats of a failed burst are swallowed without touching RAM or counts.
                if (!err) begin
                    ptr          <= ptr + AW'(1);
                    beat_count_o <= beat_count_o + 32'd1;
                end
                if (beats_left == 4'd0) begin
                    if (!s_axi_wlast) err <= 1'b1;
                end else begin
                    beats_left <= beats_left - 4'd1;
                    if (s_axi_wlast) err <= 1'b1;
                end
            end
            if (b_hs) begin
                burst_count_o <= burst_count_o + 32'd1;
                if (err) err_count_o <= err_count_o + 16'd1;
                err <= 1'b0;
            end
        end
    end

    // Sample RAM: contents survive reset.
    always_ff @(posedge clk_i) begin
        if (w_hs && !err) begin
            for (int b = 0; b < 4; b++)
                if (s_axi_wstrb[b]) ram[ptr][8*b +: 8] <= s_axi_wdata[8*b +: 8];
        end
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) rd_data_o <= '0;
        else           rd_data_o <= ram[rd_addr_i];
    end

endmodule

// File: tb/tb_pcap_axi_wr_sink.sv
module tb_pcap_axi_wr_sink;
    localparam int          AW    = 12;
    localparam int          ID_W  = 6;
    localparam int          DEPTH = 1 << AW;
    localparam logic [31:0] BASE  = 32'h1000_0000;

    logic            clk = 1'b0;
    logic            resetn;
    logic [ID_W-1:0] awid;
    logic [31:0]     awaddr;
    logic [3:0]      awlen;
    logic [2:0]      awsize;
    logic [1:0]      awburst;
    logic            awvalid, awready;
    logic [31:0]     wdata;
    logic [3:0]      wstrb;
    logic            wlast, wvalid, wready;
    logic [ID_W-1:0] bid;
    logic [1:0]      bresp;
    logic            bvalid, bready;
    logic            stall;
    logic [AW-1:0]   rd_addr;
    logic [31:0]     rd_data, beat_cnt, burst_cnt;
    logic [15:0]     err_cnt;

    pcap_axi_wr_sink #(.BASE_ADDR(BASE), .AW(AW), .ID_W(ID_W)) dut (
        .clk_i(clk), .resetn_i(resetn),
        .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen),
        .s_axi_awsize(awsize), .s_axi_awburst(awburst), .s_axi_awvalid(awvalid),
        .s_axi_awready(awready), .s_axi_wdata(wdata), .s_axi_wstrb(wstrb),
        .s_axi_wlast(wlast), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .stall_i(stall), .rd_addr_i(rd_addr), .rd_data_o(rd_data),
        .beat_count_o(beat_cnt), .burst_count_o(burst_cnt), .err_count_o(err_cnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: word-addressed memory plus expected counters.
    logic [31:0] m_ram [DEPTH];
    bit          m_vld [DEPTH];
    logic [31:0] m_beats  = 0;
    logic [31:0] m_bursts = 0;
    logic [15:0] m_errs   = 0;

    logic [31:0] d_q [16];
    logic [3:0]  s_q [16];

    // A burst is rejected when its shape is wrong or any beat falls outside the window.
    function automatic bit aw_bad(logic [31:0] a, logic [3:0] len, logic [2:0] sz, logic [1:0] bt);
        longint unsigned la = a;
        longint unsigned lb = BASE;
        if (sz != 3'd2 || bt != 2'd1 || a[1:0] != 2'd0 || la < lb) return 1'b1;
        return ((la - lb) / 4 + longint'(len) + 1) > DEPTH;
    endfunction

    function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] nw, logic [3:0] st);
        logic [31:0] r = old;
        for (int b = 0; b < 4; b++) if (st[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    task automatic read_word(input int a, output logic [31:0] d);
        @(negedge clk);
        rd_addr = AW'(a);
        @(posedge clk);
        #1 d = rd_data;
    endtask

    // Drives one burst; wl_beat is the beat index carrying wlast (-1: never).
    task automatic run_burst(input logic [31:0] addr, input logic [3:0] len, input logic [2:0] sz,
                             input logic [1:0] bt, input int wl_beat, input bit stall_tgl,
                             input int b_delay);
        logic [ID_W-1:0] id;
        logic [1:0]      exp_resp;
        int              ln, nb, cyc;
        bit              got, bad;
        id  = ID_W'($urandom);
        ln  = int'(len);
        nb  = (wl_beat >= 0 && wl_beat < ln + 1) ? wl_beat + 1 : ln + 1;
        bad = aw_bad(addr, len, sz, bt);
        cyc = 0;
        @(negedge clk);
        awvalid = 1'b1; awid = id; awaddr = addr; awlen = len; awsize = sz; awburst = bt;
        got = 1'b0;
        for (int c = 0; c < 50 && !got; c++) begin
            #1 got = awready;
            @(negedge clk);
        end
        awvalid = 1'b0;
        if (!got) begin
            n_tests++; n_fail++;
            $display("FAIL aw_timeout: awready=0 required 1 within 50 cycles");
            return;
        end
        for (int b = 0; b < nb; b++) begin
            wvalid = 1'b1; wdata = d_q[b]; wstrb = s_q[b]; wlast = (b == wl_beat);
            got = 1'b0;
            for (int c = 0; c < 40 && !got; c++) begin
                stall = stall_tgl ? cyc[0] : 1'b0;
                cyc++;
                #1;
                if (stall_tgl) begin
                    n_tests++;
                    if (wready !== !stall) begin
                        n_fail++;
                        $display("FAIL wready_vs_stall: wready=%b required %b", wready, !stall);
                    end
                end
                got = wready;
                @(negedge clk);
            end
            if (!got) begin
                n_tests++; n_fail++;
                $display("FAIL w_timeout: beat %0d never accepted", b);
                wvalid = 1'b0; wlast = 1'b0; stall = 1'b0;
                return;
            end
            if (!bad) begin
                int idx = int'((addr - BASE) >> 2) + b;
                m_ram[idx] = merge(m_vld[idx] ? m_ram[idx] : 32'h0, d_q[b], s_q[b]);
                if (!m_vld[idx] && s_q[b] != 4'hF) m_vld[idx] = 1'b0;
                else m_vld[idx] = 1'b1;
                m_beats++;
            end
        end
        wvalid = 1'b0; wlast = 1'b0; stall = 1'b0;
        exp_resp = (bad || wl_beat != ln) ? 2'b10 : 2'b00;
        bready = (b_delay == 0);
        for (int d = 0; d < b_delay; d++) begin
            #1;
            n_tests++;
            if (bvalid !== 1'b1 || awready !== 1'b0) begin
                n_fail++;
                $display("FAIL b_hold: bvalid=%b awready=%b required 1/0", bvalid, awready);
            end
            @(negedge clk);
        end
        bready = 1'b1;
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            #1 got = bvalid;
            if (got) begin
                n_tests++;
                if (bresp !== exp_resp || bid !== id) begin
                    n_fail++;
                    $display("FAIL b_resp: bresp=%b bid=%0d required %b/%0d", bresp, bid, exp_resp, id);
                end
            end
            @(negedge clk);
        end
        bready = 1'b0;
        if (!got) begin
            n_tests++; n_fail++;
            $display("FAIL b_timeout: bvalid never asserted");
            return;
        end
        m_bursts++;
        if (exp_resp == 2'b10) m_errs++;
    endtask

    task automatic test_reset;
        resetn = 1'b0;
        #12;
        n_tests++;
        if (awready !== 1'b0 || wready !== 1'b0 || bvalid !== 1'b0 || bresp !== 2'b00 || bid !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: aw=%b w=%b bv=%b br=%b bid=%0d required all 0",
                     awready, wready, bvalid, bresp, bid);
        end
        n_tests++;
        if (beat_cnt !== 0 || burst_cnt !== 0 || err_cnt !== 0 || rd_data !== 0) begin
            n_fail++;
            $display("FAIL reset_counters: beats=%0d bursts=%0d errs=%0d rd=%h required 0",
                     beat_cnt, burst_cnt, err_cnt, rd_data);
        end
        @(negedge clk);
        resetn = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single_burst;
        logic [31:0] d;
        for (int i = 0; i < 16; i++) begin d_q[i] = i; s_q[i] = 4'hF; end
        run_burst(BASE, 4'd15, 3'd2, 2'd1, 15, 1'b0, 0);
        for (int i = 0; i < 16; i++) begin
            read_word(i, d);
            n_tests++;
            if (d !== 32'(i)) begin
                n_fail++;
                $display("FAIL single_ram[%0d]: got %h required %h", i, d, i);
            end
        end
        n_tests++;
        if (beat_cnt !== 32'd16 || burst_cnt !== 32'd1 || err_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL single_counts: beats=%0d bursts=%0d errs=%0d required 16/1/0",
                     beat_cnt, burst_cnt, err_cnt);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] d;
        for (int i = 0; i < 4; i++) begin d_q[i] = $urandom; s_q[i] = 4'hF; end
        run_burst(BASE + 32'h40, 4'd3, 3'd2, 2'd1, 3, 1'b1, 0);
        for (int i = 0; i < 4; i++) begin d_q[i] = $urandom; s_q[i] = 4'hF; end
        run_burst(BASE + 32'h50, 4'd3, 3'd2, 2'd1, 3, 1'b1, 0);
        for (int i = 16; i < 24; i++) begin
            read_word(i, d);
            n_tests++;
            if (d !== m_ram[i]) begin
                n_fail++;
                $display("FAIL b2b_ram[%0d]: got %h required %h", i, d, m_ram[i]);
            end
        end
        n_tests++;
        if (burst_cnt !== 32'd3 || beat_cnt !== m_beats) begin
            n_fail++;
            $display("FAIL b2b_counts: bursts=%0d beats=%0d required 3/%0d", burst_cnt, beat_cnt, m_beats);
        end
    endtask

    task automatic test_wstrb;
        logic [31:0] d;
        d_q[0] = 32'hFFFF_FFFF; s_q[0] = 4'hF;
        run_burst(BASE + 32'h190, 4'd0, 3'd2, 2'd1, 0, 1'b0, 0);
        d_q[0] = 32'h1234_5678; s_q[0] = 4'b0011;
        run_burst(BASE + 32'h190, 4'd0, 3'd2, 2'd1, 0, 1'b0, 0);
        read_word(100, d);
        n_tests++;
        if (d !== 32'hFFFF_5678 || d !== m_ram[100]) begin
            n_fail++;
            $display("FAIL wstrb_merge: got %h required %h", d, 32'hFFFF_5678);
        end
    endtask

    task automatic test_err_addr;
        logic [31:0] d;
        logic [31:0] beats_before = beat_cnt;
        d_q[0] = 32'hDEAD_BEEF; s_q[0] = 4'hF;
        run_burst(32'h0FFF_FFFC, 4'd0, 3'd2, 2'd1, 0, 1'b0, 0);
        n_tests++;
        if (err_cnt !== 16'd1 || beat_cnt !== beats_before) begin
            n_fail++;
            $display("FAIL err_addr_counts: errs=%0d beats=%0d required 1/%0d", err_cnt, beat_cnt, beats_before);
        end
        read_word(0, d);
        n_tests++;
        if (d !== m_ram[0]) begin
            n_fail++;
            $display("FAIL err_addr_ram0: got %h required %h", d, m_ram[0]);
        end
    endtask

    task automatic test_wlast_err;
        logic [31:0] d;
        for (int i = 0; i < 4; i++) begin d_q[i] = $urandom; s_q[i] = 4'hF; end
        run_burst(BASE + 32'h300, 4'd3, 3'd2, 2'd1, -1, 1'b0, 0);
        run_burst(BASE + 32'h310, 4'd3, 3'd2, 2'd1, -1, 1'b0, 5);
        run_burst(BASE + 32'h320, 4'd3, 3'd2, 2'd1, 1, 1'b0, 0);
        n_tests++;
        if (err_cnt !== m_errs || burst_cnt !== m_bursts || beat_cnt !== m_beats) begin
            n_fail++;
            $display("FAIL wlast_counts: errs=%0d bursts=%0d beats=%0d required %0d/%0d/%0d",
                     err_cnt, burst_cnt, beat_cnt, m_errs, m_bursts, m_beats);
        end
        read_word(193, d);
        n_tests++;
        if (d !== m_ram[193]) begin
            n_fail++;
            $display("FAIL wlast_ram: got %h required %h", d, m_ram[193]);
        end
    endtask

    task automatic test_mid_reset;
        logic [31:0] d;
        bit got;
        @(negedge clk);
        awvalid = 1'b1; awid = 6'd9; awaddr = BASE + 32'h200; awlen = 4'd7; awsize = 3'd2; awburst = 2'd1;
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin #1 got = awready; @(negedge clk); end
        awvalid = 1'b0;
        for (int b = 0; b < 2; b++) begin
            wvalid = 1'b1; wdata = $urandom; wstrb = 4'hF; wlast = 1'b0;
            m_ram[128 + b] = wdata; m_vld[128 + b] = 1'b1;
            @(negedge clk);
        end
        resetn = 1'b0;
        wvalid = 1'b0;
        #1;
        n_tests++;
        if (!got || bvalid !== 1'b0 || awready !== 1'b0 || wready !== 1'b0 ||
            beat_cnt !== 0 || burst_cnt !== 0 || err_cnt !== 0) begin
            n_fail++;
            $display("FAIL mid_reset: aw_ok=%b bv=%b aw=%b w=%b beats=%0d bursts=%0d errs=%0d required 1/0/0/0/0/0/0",
                     got, bvalid, awready, wready, beat_cnt, burst_cnt, err_cnt);
        end
        m_beats = 0; m_bursts = 0; m_errs = 0;
        @(negedge clk);
        resetn = 1'b1;
        d_q[0] = $urandom; s_q[0] = 4'hF;
        run_burst(BASE + 32'h400, 4'd0, 3'd2, 2'd1, 0, 1'b0, 0);
        n_tests++;
        if (beat_cnt !== 32'd1 || burst_cnt !== 32'd1 || err_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL post_reset_counts: beats=%0d bursts=%0d errs=%0d required 1/1/0",
                     beat_cnt, burst_cnt, err_cnt);
        end
        for (int i = 128; i < 130; i++) begin
            read_word(i, d);
            n_tests++;
            if (d !== m_ram[i]) begin
                n_fail++;
                $display("FAIL mid_reset_retained[%0d]: got %h required %h", i, d, m_ram[i]);
            end
        end
    endtask

    task automatic test_random;
        logic [31:0] d, addr;
        logic [3:0]  len;
        logic [2:0]  sz;
        logic [1:0]  bt;
        int          mode, wl;
        for (int n = 0; n < 40; n++) begin
            len  = 4'($urandom_range(0, 15));
            addr = BASE + 32'($urandom_range(0, DEPTH - 16)) * 4;
            sz   = 3'd2; bt = 2'd1; wl = int'(len);
            mode = $urandom_range(0, 11);
            case (mode)
                0: addr = BASE + 32'(DEPTH - $urandom_range(1, 4)) * 4;
                1: addr = addr + 32'd1;
                2: sz = 3'd1;
                3: bt = 2'd2;
                4: wl = -1;
                5: wl = $urandom_range(0, 15);
                default: ;
            endcase
            for (int i = 0; i < 16; i++) begin d_q[i] = $urandom; s_q[i] = 4'($urandom); end
            for (int i = 0; i < 16; i++) if ($urandom_range(0, 1) == 0) s_q[i] = 4'hF;
            run_burst(addr, len, sz, bt, wl, 1'($urandom_range(0, 1)), $urandom_range(0, 3));
        end
        n_tests++;
        if (beat_cnt !== m_beats || burst_cnt !== m_bursts || err_cnt !== m_errs) begin
            n_fail++;
            $display("FAIL random_counts: beats=%0d bursts=%0d errs=%0d required %0d/%0d/%0d",
                     beat_cnt, burst_cnt, err_cnt, m_beats, m_bursts, m_errs);
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (m_vld[i]) begin
                read_word(i, d);
                n_tests++;
                if (d !== m_ram[i]) begin
                    n_fail++;
                    $display("FAIL random_ram[%0d]: got %h required %h", i, d, m_ram[i]);
                end
            end
        end
    endtask

    initial begin
        resetn = 1'b0; awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0; stall = 1'b0; rd_addr = '0;
        for (int i = 0; i < DEPTH; i++) begin m_ram[i] = 32'h0; m_vld[i] = 1'b0; end
        test_reset();
        test_single_burst();
        test_back_to_back();
        test_wstrb();
        test_err_addr();
        test_wlast_err();
        test_mid_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pcap_axi_wr_sink.md
Name: pcap_axi_wr_sink

Overview:
- AXI3 write-channel responder that terminates the PCAP DMA master's HP0 write bursts in place of the Zynq PS memory.
- Stores each accepted beat into an internal sample RAM and returns write responses.
- Exposes a synchronous read-back port and counters so simulation checkers can compare captured samples against expected tables.
- Sits between the PCAP DMA AXI master and the bench; it also serves as a synthesizable loop-back target for standalone PCAP regression.

Parameters:
- BASE_ADDR, 32'h1000_0000, byte address mapped to RAM word 0.
- AW, 12, log2 of RAM depth in 32-bit words (window = 4*2^AW bytes).
- ID_W, 6, AXI ID width.

Ports:
- clk_i  in  1  single clock; all logic on rising edge.
- resetn_i  in  1  asynchronous active-low reset.
- s_axi_awid  in  ID_W  write address ID.
- s_axi_awaddr  in  32  burst start byte address.
- s_axi_awlen  in  4  beats minus 1 (AXI3, 1..16 beats).
- s_axi_awsize  in  3  must be 3'b010 (4 bytes).
- s_axi_awburst  in  2  must be INCR (2'b01).
- s_axi_awvalid  in  1  address valid.
- s_axi_awready  out  1  address ready.
- s_axi_wdata  in  32  write data.
- s_axi_wstrb  in  4  byte strobes.
- s_axi_wlast  in  1  last beat.
- s_axi_wvalid  in  1  data valid.
- s_axi_wready  out  1  data ready.
- s_axi_bid  out  ID_W  response ID (echo of awid).
- s_axi_bresp  out  2  OKAY=00, SLVERR=10.
- s_axi_bvalid  out  1  response valid.
- s_axi_bready  in  1  response ready.
- stall_i  in  1  when high, forces wready low (backpressure injection).
- rd_addr_i  in  AW  checker read word address.
- rd_data_o  out  32  RAM word, 1-cycle latency.
- beat_count_o  out  32  total beats written to RAM.
- burst_count_o  out  32  total B responses issued.
- err_count_o  out  16  total SLVERR responses.

Behaviour:
- Reset values: awready=0, wready=0, bvalid=0, bresp=00, bid=0, all counters=0, FSM=IDLE. RAM contents are not reset. rd_data_o resets to 0.
- IDLE: awready=1. On awvalid&&awready:
  - latch id, len, and word pointer ptr=(awaddr-BASE_ADDR)>>2;
  - set err if awsize!=2, awburst!=INCR, awaddr[1:0]!=0, awaddr<BASE_ADDR, or the burst end exceeds the window;
  - load beats_left=awlen; go to DATA.
- DATA: awready=0; wready=!stall_i.
  - On each wvalid&&wready, if !err, write RAM[ptr] with wstrb byte masking, then ptr++ and beat_count++.
  - Beats of an erroring burst are accepted and discarded; beat_count is not incremented.
  - At beats_left==0: if wlast!=1, set err. Go to RESP.
  - Else beats_left--; if wlast==1 early, set err and go to RESP (remaining beats then go to the next burst; that is a master bug, flagged only).
- RESP: bvalid=1, bid=latched id, bresp=err?10:00. Hold until bready. On the handshake: burst_count++, err_count++ if err, clear err, go to IDLE.
- No write pointer wrap inside the window: a burst crossing the window end is an error.
- Single outstanding burst; no write-data interleaving; W before AW is not accepted (wready=0 in IDLE).
- Read port: rd_data_o <= RAM[rd_addr_i] every cycle. A same-address simultaneous write returns the old data.
- Counters wrap modulo 2^width.
- Reset asserted mid-burst: outputs drop to reset values asynchronously; the partially written RAM is retained; no B is issued.

Test Plan:
- Single 16-beat burst, awaddr=32'h1000_0000, data 0..15, bready=1 -> RAM[0..15]=0..15, one B with bresp=00, bid echoed, beat_count=16, burst_count=1.
- Two back-to-back 4-beat bursts at 0x1000_0040/0x1000_0050 with stall_i toggled every other cycle -> RAM[16..23] correct, wready low on stalled cycles, no beat lost, burst_count=2.
- Burst with wstrb=4'b0011 onto a word preloaded with 32'hFFFF_FFFF, data 32'h1234_5678 -> RAM word = 32'hFFFF_5678.
- awaddr=32'h0FFF_FFFC, len=0 -> beat accepted, RAM unchanged, bresp=10, err_count=1, beat_count unchanged.
- Burst with len=3 and wlast on the 4th beat low -> bresp=10; same with bready held low 5 cycles -> bvalid held, awready=0 throughout.
- resetn_i pulsed low after beat 2 of an 8-beat burst -> bvalid=0, counters=0; a following 1-beat burst completes with bresp=00.
